mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port synchronous instruction/data RAM between two requesters:
//   the CPU load/store/fetch port (port 0) and a debug/loader port (port 1).
//   Port 1 preloads or inspects memory while the CPU runs.
//   Each access runs as a fixed 4-state sequence with a one-cycle ack pulse.
//   Sits between CPU and RAM inside the top level.
// PARAMETERS
//   ADDR_W  8   memory address width (words)
//   DATA_W  16  memory word width
// PORTS
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   cpu_req     in   1       port 0 request; held until cpu_ack
//   cpu_write   in   1       port 0: 1=write, 0=read
//   cpu_addr    in   ADDR_W  port 0 address
//   cpu_wdata   in   DATA_W  port 0 write data
//   cpu_ack     out  1       port 0 completion pulse (1 cycle)
//   cpu_rdata   out  DATA_W  port 0 read data, valid while cpu_ack=1
//   dbg_req     in   1       port 1 request; same rules as port 0
//   dbg_write   in   1       port 1: 1=write, 0=read
//   dbg_addr    in   ADDR_W  port 1 address
//   dbg_wdata   in   DATA_W  port 1 write data
//   dbg_ack     out  1       port 1 completion pulse (1 cycle)
//   dbg_rdata   out  DATA_W  port 1 read data, valid while dbg_ack=1
//   mem_addr    out  ADDR_W  RAM address
//   mem_write   out  1       RAM write enable
//   mem_din     out  DATA_W  RAM write data
//   mem_dout    in   DATA_W  RAM read data, valid 1 cycle after address edge
//   busy        out  1       1 in any state other than IDLE
//   owner       out  1       port currently served (0=cpu, 1=dbg)
// BEHAVIOUR
//   - Reset (async): state=IDLE. All outputs 0: acks, mem_write, mem_addr,
//     mem_din, both rdata, busy, owner. last_owner=1, so the CPU wins first
//     contention.
//   - States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE, one cycle each.
//   - IDLE: if no req, stay. Otherwise pick a winner and latch owner, addr,
//     write and wdata into registers, then go to ACCESS. Loser's req is ignored.
//   - ACCESS: mem_addr=addr_q, mem_din=wdata_q, mem_write=write_q.
//     mem_write is high for exactly this one cycle.
//   - WAIT: mem_addr is held. For a read, capture mem_dout into the owner's
//     rdata register at the WAIT->RESP edge. For a write, rdata is unchanged.
//   - RESP: ack of the owner =1 for exactly 1 cycle, decoded from registered
//     state. The requester must drop req or present a new transaction at this
//     edge.
//   - Latency: 3 cycles from acceptance edge to ack. Throughput: 1 access per
//     4 cycles.
//   - rdata holds its last value until the next read by the same port.
//   - Outside ACCESS, mem_write=0. mem_addr/mem_din keep the last driven value.
//   - Requests arriving mid-transaction wait. They are arbitrated on the next
//     IDLE cycle, with no loss and no duplication.
//   - req dropped before ack (protocol violation): the transaction still
//     completes and acks.
//   - Reset mid-transaction: immediate return to IDLE, no ack. A write
//     interrupted before the ACCESS edge is not performed.
//   - Address wrap: none. Addresses pass through unmodified at ADDR_W bits.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin on contention.
//     - When both reqs are high in IDLE, grant the port != last_owner.
//     - last_owner updates on every grant.
//   MEM_ARB_RR_EN undefined: fixed priority, CPU always wins contention.
//     - A continuously requesting CPU starves dbg (intended for normal runs).
//     - last_owner is unused.
// TESTING
//   1 cpu read: mem[0x05]=16'hD004, cpu_req/addr=5 -> mem_write stays 0,
//     cpu_ack on 3rd cycle after acceptance, cpu_rdata=16'hD004.
//   2 dbg write then cpu read: dbg writes 16'hA5A5 @0x14 ->
//     mem_write=1 for 1 cycle, dbg_ack;
//     then cpu reads 0x14 -> cpu_rdata=16'hA5A5.
//   3 contention, fixed priority: both req continuously for 3 transactions ->
//     3 cpu_acks, 0 dbg_acks; each ack spaced 4 cycles apart.
//   4 contention with MEM_ARB_RR_EN: both req continuously ->
//     acks alternate cpu, dbg, cpu, dbg; first grant goes to cpu.
//   5 reset mid-op: dbg write 16'h1234 @0x02, assert reset during ACCESS
//     before the edge -> no dbg_ack, mem[0x02] unchanged, busy=0.
//     Next request completes normally.
//   6 idle/hold: no reqs for 20 cycles -> busy=0, acks=0, mem_write=0;
//     rdata retains the previous read value.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares a single-port synchronous RAM between the CPU port (0) and
//            a debug/loader port (1) using a fixed 4-cycle access sequence.
//            Define MEM_ARB_RR_EN for round-robin contention; the default is
//            fixed priority with the CPU always winning.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_write_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                grant_dbg;

`ifdef MEM_ARB_RR_EN
    logic                last_owner_q, last_owner_d;

    // On contention the port that was not served last wins.
    assign grant_dbg = dbg_req_i & (~cpu_req_i | ~last_owner_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign grant_dbg = dbg_req_i & ~cpu_req_i;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    owner_d = grant_dbg;
                    write_d = grant_dbg ? dbg_write_i : cpu_write_i;
                    addr_d  = grant_dbg ? dbg_addr_i  : cpu_addr_i;
                    wdata_d = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
                    state_d = S_ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = grant_dbg;
`endif
                end
            end
            S_ACCESS: state_d = S_WAIT;
            S_WAIT: begin
                // RAM output reflects the address sampled at the ACCESS edge.
                if (!write_q) begin
                    if (owner_q) begin
                        dbg_rdata_d = mem_dout_i;
                    end else begin
                        cpu_rdata_d = mem_dout_i;
                    end
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Address/data registers only change on a grant, so they hold between accesses.
    assign mem_addr_o  = addr_q;
    assign mem_din_o   = wdata_q;
    assign mem_write_o = (state_q == S_ACCESS) && write_q;
    assign cpu_ack_o   = (state_q == S_RESP) && !owner_q;
    assign dbg_ack_o   = (state_q == S_RESP) &&  owner_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign owner_o     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_write, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_write, dbg_ack;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic              busy, owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cpu_req_i   (cpu_req),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_rdata_o (cpu_rdata),
        .dbg_req_i   (dbg_req),
        .dbg_write_i (dbg_write),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_ack_o   (dbg_ack),
        .dbg_rdata_o (dbg_rdata),
        .mem_addr_o  (mem_addr),
        .mem_write_o (mem_write),
        .mem_din_o   (mem_din),
        .mem_dout_i  (mem_dout),
        .busy_o      (busy),
        .owner_o     (owner)
    );

    // Synchronous RAM with a backdoor write port for preloading.
    logic [DATA_W-1:0] ram [0:255];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we)          ram[bd_addr]  <= bd_data;
        else if (mem_write) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int cpu_acks = 0, dbg_acks = 0, wr_cycles = 0;
    always @(posedge clk) begin
        if (cpu_ack)   cpu_acks  <= cpu_acks + 1;
        if (dbg_ack)   dbg_acks  <= dbg_acks + 1;
        if (mem_write) wr_cycles <= wr_cycles + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // One single-port transaction; ack expected on the 4th falling edge after req rises.
    task automatic run_access(input logic port, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        if (port) begin dbg_req = 1; dbg_write = wr; dbg_addr = a; dbg_wdata = d; end
        else      begin cpu_req = 1; cpu_write = wr; cpu_addr = a; cpu_wdata = d; end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (mem_addr !== a || mem_write !== wr || owner !== port || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL access_phase: addr=%h we=%b owner=%b busy=%b, required addr=%h we=%b owner=%b busy=1",
                             mem_addr, mem_write, owner, busy, a, wr, port);
                end
            end
            if ((port ? dbg_ack : cpu_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
        cpu_req = 0; dbg_req = 0;
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL ack_latency: port=%0d got edge %0d, required 4 (0 = timeout)", port, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_write = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_ack, dbg_ack, mem_write, busy, owner} !== 5'b0 ||
            mem_addr !== '0 || mem_din !== '0 || cpu_rdata !== '0 || dbg_rdata !== '0) begin
            failures++;
            $display("FAIL reset_state: ack=%b%b we=%b busy=%b owner=%b addr=%h din=%h rd=%h/%h, required all 0",
                     cpu_ack, dbg_ack, mem_write, busy, owner, mem_addr, mem_din, cpu_rdata, dbg_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_cpu_read;
        int w0, c0, d0;
        bd_write(8'h05, 16'hD004);
        w0 = wr_cycles; c0 = cpu_acks; d0 = dbg_acks;
        run_access(1'b0, 1'b0, 8'h05, 16'h0000);
        checks++;
        if (cpu_rdata !== 16'hD004) begin
            failures++;
            $display("FAIL cpu_read_data: got %h, required d004", cpu_rdata);
        end
        checks++;
        if (wr_cycles != w0 || cpu_acks != c0 + 1 || dbg_acks != d0) begin
            failures++;
            $display("FAIL cpu_read_counts: writes=%0d cpu_acks=%0d dbg_acks=%0d, required 0/1/0",
                     wr_cycles - w0, cpu_acks - c0, dbg_acks - d0);
        end
    endtask

    task automatic test_dbg_write_cpu_read;
        int w0, c0, d0;
        w0 = wr_cycles; c0 = cpu_acks; d0 = dbg_acks;
        run_access(1'b1, 1'b1, 8'h14, 16'hA5A5);
        checks++;
        if (wr_cycles != w0 + 1 || dbg_acks != d0 + 1 || cpu_acks != c0) begin
            failures++;
            $display("FAIL dbg_write_counts: writes=%0d dbg_acks=%0d cpu_acks=%0d, required 1/1/0",
                     wr_cycles - w0, dbg_acks - d0, cpu_acks - c0);
        end
        checks++;
        if (ram[8'h14] !== 16'hA5A5 || dbg_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL dbg_write_effect: ram=%h dbg_rdata=%h, required a5a5 and 0000", ram[8'h14], dbg_rdata);
        end
        run_access(1'b0, 1'b0, 8'h14, 16'h0000);
        checks++;
        if (cpu_rdata !== 16'hA5A5) begin
            failures++;
            $display("FAIL cpu_readback: got %h, required a5a5", cpu_rdata);
        end
    endtask

    task automatic test_contention;
        int  n;
        logic exp_dbg;
        n = 0;
        @(posedge clk); #1;
        cpu_req = 1; cpu_write = 0; cpu_addr = 8'h05;
        dbg_req = 1; dbg_write = 0; dbg_addr = 8'h14;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
`ifdef MEM_ARB_RR_EN
                exp_dbg = n[0];
`else
                exp_dbg = 1'b0;
`endif
                checks++;
                if (i != 4 * (n + 1) || dbg_ack !== exp_dbg || cpu_ack !== !exp_dbg) begin
                    failures++;
                    $display("FAIL contention_ack%0d: edge=%0d cpu=%b dbg=%b, required edge=%0d dbg=%b",
                             n, i, cpu_ack, dbg_ack, 4 * (n + 1), exp_dbg);
                end
                n++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL contention_count: got %0d acks, required 4", n);
        end
        @(posedge clk); #1;
        checks++;
`ifdef MEM_ARB_RR_EN
        if (dbg_rdata !== 16'hA5A5 || cpu_rdata !== 16'hD004) begin
            failures++;
            $display("FAIL contention_data: cpu=%h dbg=%h, required d004 a5a5", cpu_rdata, dbg_rdata);
        end
`else
        if (dbg_rdata !== 16'h0000 || cpu_rdata !== 16'hD004) begin
            failures++;
            $display("FAIL contention_data: cpu=%h dbg=%h, required d004 0000", cpu_rdata, dbg_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid_op;
        int d0;
        bd_write(8'h02, 16'h0BAD);
        d0 = dbg_acks;
        @(posedge clk); #1;
        dbg_req = 1; dbg_write = 1; dbg_addr = 8'h02; dbg_wdata = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            failures++;
            $display("FAIL midop_access: mem_write=%b, required 1", mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL midop_async_reset: busy=%b we=%b, required 0 0", busy, mem_write);
        end
        dbg_req = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dbg_acks != d0 || ram[8'h02] !== 16'h0BAD || busy !== 1'b0) begin
            failures++;
            $display("FAIL midop_aborted: dbg_acks=%0d ram=%h busy=%b, required 0 0bad 0",
                     dbg_acks - d0, ram[8'h02], busy);
        end
        run_access(1'b1, 1'b0, 8'h02, 16'h0000);
        checks++;
        if (dbg_rdata !== 16'h0BAD) begin
            failures++;
            $display("FAIL midop_recovery: dbg_rdata=%h, required 0bad", dbg_rdata);
        end
    endtask

    task automatic test_idle_hold;
        run_access(1'b0, 1'b0, 8'h14, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, cpu_ack, dbg_ack, mem_write} !== 4'b0) begin
                failures++;
                $display("FAIL idle_cycle%0d: busy=%b acks=%b%b we=%b, required 0", i, busy, cpu_ack, dbg_ack, mem_write);
            end
        end
        checks++;
        if (cpu_rdata !== 16'hA5A5 || dbg_rdata !== 16'h0BAD) begin
            failures++;
            $display("FAIL idle_rdata_hold: cpu=%h dbg=%h, required a5a5 0bad", cpu_rdata, dbg_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_contention();
        test_reset_mid_op();
        test_idle_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
